// File: rtl/sound_pkg.sv
// Shared types and the default note table for the sound-effect sequencer.
package sound_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StPlay = 1'b1
   } state_e;

   typedef struct packed {
      logic [15:0] half_period;
      logic [7:0]  duration;
   } note_t;

   // A zero duration marks the end of an effect's note list.
   function automatic note_t note_lookup(input int unsigned effect, input int unsigned index);
      note_t n;
      n.half_period = 16'd0;
      n.duration    = 8'd0;
      case (effect)
         0: begin
            if (index == 0) begin n.half_period = 16'd100; n.duration = 8'd1; end
         end
         1: begin
            case (index)
               0: begin n.half_period = 16'd150; n.duration = 8'd2; end
               1: begin n.half_period = 16'd100; n.duration = 8'd2; end
               default: ;
            endcase
         end
         2: begin
            case (index)
               0: begin n.half_period = 16'd200; n.duration = 8'd2; end
               1: begin n.half_period = 16'd150; n.duration = 8'd2; end
               2: begin n.half_period = 16'd100; n.duration = 8'd4; end
               default: ;
            endcase
         end
         3: begin
            case (index)
               0: begin n.half_period = 16'd100; n.duration = 8'd4; end
               1: begin n.half_period = 16'd0;   n.duration = 8'd2; end
               2: begin n.half_period = 16'd250; n.duration = 8'd8; end
               default: ;
            endcase
         end
         default: ;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: half-period counter plus phase toggle, with load and enable.
module tone_gen #(
   parameter int unsigned PERIOD_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] half_period,
   output logic                phase
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (load) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (enable) begin
         // A zero half-period is a rest: hold the output low.
         if (half_period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (cnt_q == half_period - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/sound_seq.sv
// Priority sound-effect sequencer stepping a note table on vsync frame ticks.
// Optional SOUND_QUEUE_EN keeps one pending lower-priority trigger to play after the current effect.
module sound_seq
   import sound_pkg::*;
#(
   parameter int unsigned NUM_EFFECTS = 4,
   parameter int unsigned PERIOD_W    = 10,
   parameter int unsigned MAX_NOTES   = 4,
   parameter int unsigned DUR_W       = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           vsync,
   input  logic [NUM_EFFECTS-1:0]         trigger,
   input  logic                           mute,
   output logic                           audio,
   output logic                           busy,
   output logic [$clog2(NUM_EFFECTS)-1:0] effect_id
);

   localparam int unsigned ID_W  = $clog2(NUM_EFFECTS);
   localparam int unsigned IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

   state_e                 state_q, state_d;
   logic [NUM_EFFECTS-1:0] trig_q;
   logic                   vsync_q;
   logic [ID_W-1:0]        id_q, id_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DUR_W-1:0]       dur_q, dur_d;

   logic                   tick;
   logic                   trig_any;
   logic [ID_W-1:0]        trig_idx;
   logic                   accept;
   logic                   load_en;
   logic [ID_W-1:0]        load_id;
   logic                   tone_load;
   logic                   last_note;
   logic                   tone_phase;
   note_t                  cur_note, next_note, first_note;
   logic                   unused_note_bits;

   assign tick = vsync & ~vsync_q;

   always_comb begin
      trig_any = |trig_q;
      trig_idx = '0;
      for (int i = 0; i < NUM_EFFECTS; i++) begin
         if (trig_q[i]) trig_idx = ID_W'(i);
      end
   end

   assign accept = trig_any && ((state_q == StIdle) || (trig_idx >= id_q));

`ifdef SOUND_QUEUE_EN
   logic            pend_valid_q, pend_valid_d;
   logic [ID_W-1:0] pend_id_q, pend_id_d;
   logic            pend_start;

   assign pend_start = !accept && (state_q == StIdle) && pend_valid_q;

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_id_d    = pend_id_q;
      if (pend_start) pend_valid_d = 1'b0;
      if (trig_any && (state_q == StPlay) && !accept &&
          (!pend_valid_q || (trig_idx > pend_id_q))) begin
         pend_valid_d = 1'b1;
         pend_id_d    = trig_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_q <= 1'b0;
         pend_id_q    <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
      end
   end

   assign load_en = accept || pend_start;
   assign load_id = accept ? trig_idx : pend_id_q;
`else
   assign load_en = accept;
   assign load_id = trig_idx;
`endif

   assign cur_note   = note_lookup(32'(id_q), 32'(idx_q));
   assign next_note  = note_lookup(32'(id_q), 32'(idx_q) + 32'd1);
   assign first_note = note_lookup(32'(load_id), 32'd0);
   assign last_note  = (idx_q == IDX_W'(MAX_NOTES - 1)) || (next_note.duration == 8'd0);

   assign unused_note_bits = ^{cur_note, next_note, first_note};

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      idx_d     = idx_q;
      dur_d     = dur_q;
      tone_load = 1'b0;
      if (load_en) begin
         // A new trigger overrides any frame tick or effect end in the same cycle.
         state_d   = StPlay;
         id_d      = load_id;
         idx_d     = '0;
         dur_d     = first_note.duration[DUR_W-1:0];
         tone_load = 1'b1;
      end else if ((state_q == StPlay) && tick) begin
         if (dur_q <= DUR_W'(1)) begin
            tone_load = 1'b1;
            if (last_note) begin
               state_d = StIdle;
               id_d    = '0;
               idx_d   = '0;
               dur_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
               dur_d = next_note.duration[DUR_W-1:0];
            end
         end else begin
            dur_d = dur_q - DUR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         trig_q  <= '0;
         vsync_q <= 1'b0;
         id_q    <= '0;
         idx_q   <= '0;
         dur_q   <= '0;
      end else begin
         state_q <= state_d;
         trig_q  <= trigger;
         vsync_q <= vsync;
         id_q    <= id_d;
         idx_q   <= idx_d;
         dur_q   <= dur_d;
      end
   end

   tone_gen #(
      .PERIOD_W (PERIOD_W)
   ) u_tone_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (tone_load),
      .enable      (state_q == StPlay),
      .half_period (cur_note.half_period[PERIOD_W-1:0]),
      .phase       (tone_phase)
   );

   assign audio     = tone_phase & ~mute;
   assign busy      = (state_q == StPlay);
   assign effect_id = id_q;

endmodule

// File: tb/tb_sound_seq.sv
// Directed self-checking bench for sound_seq with the default note table.
module tb_sound_seq;

   logic       clk;
   logic       rst;
   logic       vsync;
   logic [3:0] trigger;
   logic       mute;
   logic       audio;
   logic       busy;
   logic [1:0] effect_id;

   int vectors;
   int miscompares;

   sound_seq u_dut (
      .clk       (clk),
      .rst       (rst),
      .vsync     (vsync),
      .trigger   (trigger),
      .mute      (mute),
      .audio     (audio),
      .busy      (busy),
      .effect_id (effect_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame();
      vsync = 1'b1;
      step(1);
      vsync = 1'b0;
      step(1);
   endtask

   // Trigger sampled at the first edge; the effect is loaded at the second.
   task automatic pulse(input logic [3:0] t);
      trigger = t;
      step(1);
      trigger = 4'b0000;
      step(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      trigger = 4'b1000;
      step(3);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
      vectors++; if (effect_id !== 2'd0) begin miscompares++; $display("FAIL rst_id got %0d want 0", effect_id); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL rst_audio got %b want 0", audio); end
      rst = 1'b0;
      trigger = 4'b0000;
      step(2);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_trig_ignored busy got %b want 0", busy); end
   endtask

   task automatic test_e0_tone();
      trigger = 4'b0001;
      step(1);
      trigger = 4'b0000;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL e0_latency busy got %b want 0", busy); end
      step(1);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL e0_load busy got %b want 1", busy); end
      vectors++; if (effect_id !== 2'd0) begin miscompares++; $display("FAIL e0_load id got %0d want 0", effect_id); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e0_load audio got %b want 0", audio); end
      step(99);
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e0_pre99 audio got %b want 0", audio); end
      step(1);
      vectors++; if (audio !== 1'b1) begin miscompares++; $display("FAIL e0_t100 audio got %b want 1", audio); end
      step(99);
      vectors++; if (audio !== 1'b1) begin miscompares++; $display("FAIL e0_t199 audio got %b want 1", audio); end
      step(1);
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e0_t200 audio got %b want 0", audio); end
      vsync = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL e0_end busy got %b want 0", busy); end
      vectors++; if (effect_id !== 2'd0) begin miscompares++; $display("FAIL e0_end id got %0d want 0", effect_id); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e0_end audio got %b want 0", audio); end
      vsync = 1'b0;
      step(1);
   endtask

   task automatic test_e3_sequence(input logic m);
      logic exp_a;
      exp_a = ~m;
      mute = m;
      pulse(4'b1000);
      vectors++; if (effect_id !== 2'd3) begin miscompares++; $display("FAIL e3_m%0b id got %0d want 3", m, effect_id); end
      step(100);
      vectors++; if (audio !== exp_a) begin miscompares++; $display("FAIL e3_m%0b note0 audio got %b want %b", m, audio, exp_a); end
      repeat (3) frame();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL e3_m%0b f3 busy got %b want 1", m, busy); end
      vsync = 1'b1;
      step(1);
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e3_m%0b rest_load audio got %b want 0", m, audio); end
      vsync = 1'b0;
      step(50);
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e3_m%0b rest audio got %b want 0", m, audio); end
      frame();
      vsync = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL e3_m%0b n2_load busy got %b want 1", m, busy); end
      vsync = 1'b0;
      step(249);
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e3_m%0b n2_t249 audio got %b want 0", m, audio); end
      step(1);
      vectors++; if (audio !== exp_a) begin miscompares++; $display("FAIL e3_m%0b n2_t250 audio got %b want %b", m, audio, exp_a); end
      if (m) begin
         mute = 1'b0;
         #1;
         vectors++; if (audio !== 1'b1) begin miscompares++; $display("FAIL e3_unmute phase audio got %b want 1", audio); end
      end
      repeat (7) frame();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL e3_m%0b f13 busy got %b want 1", m, busy); end
      vectors++; if (effect_id !== 2'd3) begin miscompares++; $display("FAIL e3_m%0b f13 id got %0d want 3", m, effect_id); end
      vsync = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL e3_m%0b end busy got %b want 0", m, busy); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL e3_m%0b end audio got %b want 0", m, audio); end
      vsync = 1'b0;
      mute = 1'b0;
      step(1);
   endtask

   task automatic test_drop();
      pulse(4'b0100);
      step(10);
      pulse(4'b0010);
      vectors++; if (effect_id !== 2'd2) begin miscompares++; $display("FAIL drop id got %0d want 2", effect_id); end
      repeat (7) frame();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drop f7 busy got %b want 1", busy); end
      vsync = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop e2_end busy got %b want 0", busy); end
      vsync = 1'b0;
      step(1);
`ifdef SOUND_QUEUE_EN
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL queue start busy got %b want 1", busy); end
      vectors++; if (effect_id !== 2'd1) begin miscompares++; $display("FAIL queue start id got %0d want 1", effect_id); end
`else
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop lost busy got %b want 0", busy); end
      vectors++; if (effect_id !== 2'd0) begin miscompares++; $display("FAIL drop lost id got %0d want 0", effect_id); end
`endif
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_priority();
      pulse(4'b0101);
      vectors++; if (effect_id !== 2'd2) begin miscompares++; $display("FAIL prio id got %0d want 2", effect_id); end
      step(30);
      pulse(4'b1000);
      vectors++; if (effect_id !== 2'd3) begin miscompares++; $display("FAIL preempt id got %0d want 3", effect_id); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL preempt audio got %b want 0", audio); end
      step(99);
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL preempt t99 audio got %b want 0", audio); end
      step(1);
      vectors++; if (audio !== 1'b1) begin miscompares++; $display("FAIL preempt t100 audio got %b want 1", audio); end
      pulse(4'b0001);
      vectors++; if (effect_id !== 2'd3) begin miscompares++; $display("FAIL low_drop id got %0d want 3", effect_id); end
      rst = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst busy got %b want 0", busy); end
      vectors++; if (effect_id !== 2'd0) begin miscompares++; $display("FAIL mid_rst id got %0d want 0", effect_id); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL mid_rst audio got %b want 0", audio); end
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_back_to_back();
      pulse(4'b0001);
      step(5);
      trigger = 4'b0001;
      step(1);
      trigger = 4'b0000;
      vsync = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b trig_wins busy got %b want 1", busy); end
      vectors++; if (audio !== 1'b0) begin miscompares++; $display("FAIL b2b reload audio got %b want 0", audio); end
      vsync = 1'b0;
      step(1);
      vsync = 1'b1;
      step(1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b end busy got %b want 0", busy); end
      vsync = 1'b0;
      step(1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      vsync       = 1'b0;
      trigger     = 4'b0000;
      mute        = 1'b0;
      test_reset();
      test_e0_tone();
      test_e3_sequence(1'b0);
      test_e3_sequence(1'b1);
      test_drop();
      test_priority();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sound_seq.md
SOUND_SEQ -- requirements
Module: sound_seq

Interface
REQ-001 Parameter NUM_EFFECTS, default 4, number of sound-effect trigger inputs; index 0 is the lowest priority.
REQ-002 Parameter PERIOD_W, default 10, width of the tone half-period in clock cycles.
REQ-003 Parameter MAX_NOTES, default 4, notes per effect in the note table.
REQ-004 Parameter DUR_W, default 4, width of the note duration in frames.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 vsync  input  1  frame reference (level); each rising edge is one frame tick.
REQ-008 trigger  input  NUM_EFFECTS  one-cycle event pulses (e.g. tick, eat, success, failure).
REQ-009 mute  input  1  forces audio low; sequencing continues.
REQ-010 audio  output  1  square-wave output.
REQ-011 busy  output  1  high while an effect is playing.
REQ-012 effect_id  output  $clog2(NUM_EFFECTS)  index of the playing effect; 0 when idle.

Function
REQ-013 FSM states: IDLE, PLAY; the only transitions are IDLE->PLAY on an accepted trigger, PLAY->PLAY on a pre-empting trigger or note advance, and PLAY->IDLE at effect end.
REQ-014 Accept: when several trigger bits are set in one cycle, the highest set index is taken.
REQ-015 Pre-emption: in PLAY, a trigger with index >= effect_id restarts at note 0 of that effect; a lower index is dropped (unless SOUND_QUEUE_EN).
REQ-016 Latency: a trigger sampled at edge t gives busy=1, effect_id and note 0 loaded at edge t+1.
REQ-017 Note load: half-period counter=0, audio=0, duration counter=table duration.
REQ-018 Tone: in PLAY with half_period hp!=0, the counter increments each cycle; at hp-1 it wraps to 0 and audio toggles (period 2*hp cycles).
REQ-019 Rest: hp==0 holds audio=0 for the note duration.
REQ-020 Frame tick = vsync registered low, now high; each tick in PLAY decrements the duration counter.
REQ-021 On the tick that brings duration to 0: advance to the next note; end the effect if note index==MAX_NOTES-1 or the next entry's duration==0.
REQ-022 Effect end: IDLE, busy=0, effect_id=0, audio=0 on the following edge.
REQ-023 A trigger in the same cycle as a frame tick or effect end wins; the new effect loads as in REQ-017.
REQ-024 mute gates only the output register: audio=0 while mute=1; internal toggle phase is unaffected.
REQ-025 Counter arithmetic is unsigned, fixed width; there is no overflow path beyond hp-1 wrap.

Reset
REQ-026 rst=1 at an edge: state=IDLE, audio=0, busy=0, effect_id=0, all counters=0, vsync history=0, queue empty.
REQ-027 Reset mid-effect aborts it; triggers during reset are ignored.

Configuration
REQ-028 Macro SOUND_QUEUE_EN defined: a one-entry pending slot captures the highest dropped lower-priority trigger (a newer drop replaces it only if its index is higher); it starts on effect end, one cycle after IDLE.
REQ-029 SOUND_QUEUE_EN undefined: dropped triggers are lost; no pending-slot logic is present.

Structure
REQ-030 Package sound_pkg holds the state enum, note struct {half_period, duration}, and the default note table function note_lookup(effect, index).
REQ-031 Default table: e0 {100,1}; e1 {150,2},{100,2}; e2 {200,2},{150,2},{100,4}; e3 {100,4},{0,2},{250,8}; unused entries duration 0.
REQ-032 Sub-module tone_gen (half-period counter plus toggle, with load/enable) is instantiated once.

Verification
REQ-033 trigger=0001, then 1 frame: audio toggles every 100 cycles; busy falls the edge after the first frame tick.
REQ-034 trigger=1000: 4 frames at hp=100, 2 frames audio=0, 8 frames at hp=250, then IDLE.
REQ-035 e2 playing, trigger=0010: ignored, e2 completes; with SOUND_QUEUE_EN, e1 starts the cycle after e2 ends.
REQ-036 trigger=0101 in one cycle: effect_id=2; a later trigger=1000 mid-note restarts as effect 3 note 0 next edge.
REQ-037 mute=1 during e3: audio stays 0, busy and timing unchanged; rst mid-effect: all outputs 0 next edge.
